mem_access_sequencer: RTL and testbench

- Parametrised MEM-stage memory sequencer for the pipelined LC-3b datapath; replaces the fixed 2-bit response counter and the global-load logic.
- Issues direct and N-level indirect data accesses (LDI/STI generalised), byte-lane stores, and generates the pipeline-wide stage_advance strobe.
- Unlike the current logic, it latches i-side and d-side responses independently, so they need not arrive in the same cycle.

---
 rtl/mem_access_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// MEM-stage data-memory sequencer for the pipelined LC-3b: direct and N-level indirect
// accesses, byte-lane stores, and the pipeline-wide stage_advance strobe.
module mem_access_sequencer #(
    parameter int WIDTH          = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int INDIRECT_DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic                  req_indirect,
    input  logic                  req_byte,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    input  logic                  i_mem_resp,
    input  logic                  d_mem_resp,
    input  logic [WIDTH-1:0]      d_mem_rdata,
    output logic                  d_mem_read,
    output logic                  d_mem_write,
    output logic [ADDR_WIDTH-1:0] d_mem_address,
    output logic [WIDTH-1:0]      d_mem_wdata,
    output logic [WIDTH/8-1:0]    d_mem_byte_enable,
    output logic [WIDTH-1:0]      rdata,
    output logic                  stage_advance,
    output logic                  busy
);

    localparam int LANES       = WIDTH / 8;
    localparam int LANE_BITS   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LEVEL_W     = (INDIRECT_DEPTH > 0) ? $clog2(INDIRECT_DEPTH + 1) : 1;
    localparam bit INDIRECT_EN = (INDIRECT_DEPTH > 0);

    localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(INDIRECT_DEPTH);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PTR    = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] WAIT_I = 2'd3;

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [LEVEL_W-1:0]    level;
    logic [LEVEL_W-1:0]    level_next;
    logic                  i_done;
    logic [ADDR_WIDTH-1:0] ptr;

    logic                  lat_write;
    logic                  lat_byte;
    logic                  lat_indirect;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [WIDTH-1:0]      lat_wdata;

    logic                  mem_op;
    logic                  req_is_write;
    logic                  req_ind;
    logic                  i_ready;

    logic                  rd;
    logic                  wr;
    logic                  advance;
    logic                  load_ptr;
    logic                  load_rdata;
    logic                  final_write;
    logic                  cur_byte;
    logic [WIDTH-1:0]      cur_wdata;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LANE_BITS-1:0]  lane;

    // Read wins over write when both are requested
    assign mem_op       = req_valid & (req_read | req_write);
    assign req_is_write = req_write & ~req_read;
    assign req_ind      = req_indirect & INDIRECT_EN;
    assign i_ready      = i_mem_resp | i_done;

    always_comb begin
        next_state  = state;
        level_next  = level;
        rd          = 1'b0;
        wr          = 1'b0;
        advance     = 1'b0;
        load_ptr    = 1'b0;
        load_rdata  = 1'b0;
        final_write = 1'b0;
        cur_byte    = 1'b0;
        cur_wdata   = lat_wdata;
        cur_addr    = lat_addr;

        case (state)
            IDLE: begin
                cur_addr  = req_addr;
                cur_wdata = req_wdata;
                if (!mem_op) begin
                    advance = i_mem_resp;
                end else if (req_ind) begin
                    // Pointer reads are always word reads, even for a store
                    rd = 1'b1;
                    if (d_mem_resp) begin
                        load_ptr   = 1'b1;
                        level_next = LEVEL_ONE;
                        next_state = (LEVEL_ONE == LEVEL_LAST) ? ACCESS : PTR;
                    end else begin
                        level_next = '0;
                        next_state = PTR;
                    end
                end else begin
                    rd          = ~req_is_write;
                    wr          = req_is_write;
                    final_write = req_is_write;
                    cur_byte    = req_byte;
                    if (d_mem_resp) begin
                        load_rdata = ~req_is_write;
                        if (i_mem_resp) begin
                            advance = 1'b1;
                        end else begin
                            next_state = WAIT_I;
                        end
                    end else begin
                        next_state = ACCESS;
                    end
                end
            end

            PTR: begin
                rd       = 1'b1;
                cur_addr = (level == '0) ? lat_addr : ptr;
                if (d_mem_resp) begin
                    load_ptr   = 1'b1;
                    level_next = level + LEVEL_ONE;
                    if (level + LEVEL_ONE == LEVEL_LAST) begin
                        next_state = ACCESS;
                    end
                end
            end

            ACCESS: begin
                cur_addr    = lat_indirect ? ptr : lat_addr;
                rd          = ~lat_write;
                wr          = lat_write;
                final_write = lat_write;
                cur_byte    = lat_byte;
                if (d_mem_resp) begin
                    load_rdata = ~lat_write;
                    if (i_ready) begin
                        advance    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = WAIT_I;
                    end
                end
            end

            WAIT_I: begin
                if (i_ready) begin
                    advance    = 1'b1;
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign lane = cur_addr[LANE_BITS-1:0];

    // Byte stores get a one-hot enable and the low byte copied into every lane
    always_comb begin
        d_mem_byte_enable = '1;
        d_mem_wdata       = cur_wdata;
        if (cur_byte) begin
            d_mem_wdata = {LANES{cur_wdata[7:0]}};
            if (final_write && (LANES > 1)) begin
                d_mem_byte_enable = LANES'(1) << lane;
            end
        end
    end

    assign d_mem_address = cur_addr;
    assign d_mem_read    = rd & ~reset;
    assign d_mem_write   = wr & ~reset;
    assign stage_advance = advance & ~reset;
    assign busy          = (state != IDLE) & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            level        <= '0;
            i_done       <= 1'b0;
            ptr          <= '0;
            rdata        <= '0;
            lat_write    <= 1'b0;
            lat_byte     <= 1'b0;
            lat_indirect <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
        end else begin
            state <= next_state;
            level <= level_next;
            if (load_ptr) begin
                ptr <= d_mem_rdata[ADDR_WIDTH-1:0];
            end
            if (load_rdata) begin
                rdata <= d_mem_rdata;
            end
            // Remember an early fetch completion until the stage can advance
            if (advance) begin
                i_done <= 1'b0;
            end else if ((state != IDLE) && i_mem_resp) begin
                i_done <= 1'b1;
            end
            if ((state == IDLE) && mem_op) begin
                lat_write    <= req_is_write;
                lat_byte     <= req_byte;
                lat_indirect <= req_ind;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer; three instances cover indirection depths 1, 2 and 3
// sharing one stimulus bus, and each scenario checks only the instance it targets.
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic        req_indirect;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        i_mem_resp;
    logic        d_mem_resp;
    logic [15:0] d_mem_rdata;

    logic        rd1, wr1, adv1, busy1;
    logic [15:0] addr1, wd1, rdata1;
    logic [1:0]  be1;
    logic        rd2, wr2, adv2, busy2;
    logic [15:0] addr2, wd2, rdata2;
    logic [1:0]  be2;
    logic        rd3, wr3, adv3, busy3;
    logic [15:0] addr3, wd3, rdata3;
    logic [1:0]  be3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_sequencer #(.WIDTH(16), .ADDR_WIDTH(16), .INDIRECT_DEPTH(1)) u1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .req_indirect(req_indirect), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata), .i_mem_resp(i_mem_resp),
        .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata), .d_mem_read(rd1),
        .d_mem_write(wr1), .d_mem_address(addr1), .d_mem_wdata(wd1),
        .d_mem_byte_enable(be1), .rdata(rdata1), .stage_advance(adv1), .busy(busy1));

    mem_access_sequencer #(.WIDTH(16), .ADDR_WIDTH(16), .INDIRECT_DEPTH(2)) u2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .req_indirect(req_indirect), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata), .i_mem_resp(i_mem_resp),
        .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata), .d_mem_read(rd2),
        .d_mem_write(wr2), .d_mem_address(addr2), .d_mem_wdata(wd2),
        .d_mem_byte_enable(be2), .rdata(rdata2), .stage_advance(adv2), .busy(busy2));

    mem_access_sequencer #(.WIDTH(16), .ADDR_WIDTH(16), .INDIRECT_DEPTH(3)) u3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .req_indirect(req_indirect), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata), .i_mem_resp(i_mem_resp),
        .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata), .d_mem_read(rd3),
        .d_mem_write(wr3), .d_mem_address(addr3), .d_mem_wdata(wd3),
        .d_mem_byte_enable(be3), .rdata(rdata3), .stage_advance(adv3), .busy(busy3));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then wait for the sampling edge
    task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic ind,
                                 input logic byt, input logic [15:0] a, input logic [15:0] wd,
                                 input logic ir, input logic dr, input logic [15:0] drd);
        @(posedge clk);
        #1;
        req_valid    = v;
        req_read     = rd;
        req_write    = wr;
        req_indirect = ind;
        req_byte     = byt;
        req_addr     = a;
        req_wdata    = wd;
        i_mem_resp   = ir;
        d_mem_resp   = dr;
        d_mem_rdata  = drd;
        @(negedge clk);
    endtask

    task automatic idleInputs();
        req_valid    = 1'b0;
        req_read     = 1'b0;
        req_write    = 1'b0;
        req_indirect = 1'b0;
        req_byte     = 1'b0;
        req_addr     = 16'h0;
        req_wdata    = 16'h0;
        i_mem_resp   = 1'b0;
        d_mem_resp   = 1'b0;
        d_mem_rdata  = 16'h0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        idleInputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        idleInputs();
        #2;

        // Reset held with a live request: everything gated off
        reset = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_read   = 1'b1;
        i_mem_resp = 1'b1;
        @(negedge clk);
        checkOutput("rst_read", rd1, 0);
        checkOutput("rst_write", wr1, 0);
        checkOutput("rst_adv", adv1, 0);
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_rdata", rdata1, 16'h0);
        checkOutput("rst_read3", rd3, 0);
        idleInputs();
        @(negedge clk);
        reset = 1'b0;

        // No memory op: advance follows i_mem_resp
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, (c == 3), 0, 16'h0);
            checkOutput($sformatf("noop_adv_c%0d", c), adv1, (c == 3));
            checkOutput($sformatf("noop_read_c%0d", c), rd1, 0);
            checkOutput($sformatf("noop_write_c%0d", c), wr1, 0);
        end

        // Direct LDR, data first, fetch late
        applyStimulus(1, 1, 0, 0, 0, 16'h1234, 16'h0, 0, 0, 16'h0);
        checkOutput("ldr_c0_read", rd1, 1);
        checkOutput("ldr_c0_addr", addr1, 16'h1234);
        checkOutput("ldr_c0_busy", busy1, 0);
        applyStimulus(1, 1, 0, 0, 0, 16'hFFFF, 16'h0, 0, 0, 16'h0);
        checkOutput("ldr_c1_addr", addr1, 16'h1234);
        checkOutput("ldr_c1_read", rd1, 1);
        checkOutput("ldr_c1_busy", busy1, 1);
        applyStimulus(1, 1, 0, 0, 0, 16'hFFFF, 16'h0, 0, 1, 16'hBEEF);
        checkOutput("ldr_c2_read", rd1, 1);
        checkOutput("ldr_c2_adv", adv1, 0);
        for (int c = 3; c < 5; c++) begin
            applyStimulus(1, 1, 0, 0, 0, 16'hFFFF, 16'h0, 0, 0, 16'h0);
            checkOutput($sformatf("ldr_wait_read_c%0d", c), rd1, 0);
            checkOutput($sformatf("ldr_wait_busy_c%0d", c), busy1, 1);
            checkOutput($sformatf("ldr_wait_adv_c%0d", c), adv1, 0);
            checkOutput($sformatf("ldr_wait_rdata_c%0d", c), rdata1, 16'hBEEF);
        end
        applyStimulus(1, 1, 0, 0, 0, 16'hFFFF, 16'h0, 1, 0, 16'h0);
        checkOutput("ldr_c5_adv", adv1, 1);
        checkOutput("ldr_c5_read", rd1, 0);
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        checkOutput("ldr_c6_busy", busy1, 0);
        checkOutput("ldr_c6_adv", adv1, 0);
        checkOutput("ldr_c6_rdata", rdata1, 16'hBEEF);

        // Direct LDR, fetch arrives before data and is remembered
        applyStimulus(1, 1, 0, 0, 0, 16'h1234, 16'h0, 0, 0, 16'h0);
        applyStimulus(1, 1, 0, 0, 0, 16'h1234, 16'h0, 1, 0, 16'h0);
        checkOutput("ldr2_c1_adv", adv1, 0);
        checkOutput("ldr2_c1_busy", busy1, 1);
        applyStimulus(1, 1, 0, 0, 0, 16'h1234, 16'h0, 0, 1, 16'h1111);
        checkOutput("ldr2_c2_adv", adv1, 1);
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        checkOutput("ldr2_c3_busy", busy1, 0);
        checkOutput("ldr2_c3_rdata", rdata1, 16'h1111);

        // Both responses in the issue cycle: advance without leaving IDLE
        applyStimulus(1, 1, 0, 0, 0, 16'h0020, 16'h0, 1, 1, 16'h2222);
        checkOutput("fast_adv", adv1, 1);
        checkOutput("fast_read", rd1, 1);
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        checkOutput("fast_busy", busy1, 0);
        checkOutput("fast_adv_after", adv1, 0);
        checkOutput("fast_rdata", rdata1, 16'h2222);

        // Read and write together: the read wins
        applyStimulus(1, 1, 1, 0, 0, 16'h0200, 16'h5555, 1, 1, 16'h7777);
        checkOutput("prec_read", rd1, 1);
        checkOutput("prec_write", wr1, 0);
        checkOutput("prec_be", be1, 2'b11);
        checkOutput("prec_adv", adv1, 1);
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        checkOutput("prec_rdata", rdata1, 16'h7777);

        // STB to the upper lane, held until the data response
        applyStimulus(1, 0, 1, 0, 1, 16'h0101, 16'h00AB, 0, 0, 16'h0);
        checkOutput("stb_c0_write", wr1, 1);
        checkOutput("stb_c0_read", rd1, 0);
        checkOutput("stb_c0_be", be1, 2'b10);
        checkOutput("stb_c0_wdata", wd1, 16'hABAB);
        checkOutput("stb_c0_addr", addr1, 16'h0101);
        applyStimulus(1, 0, 1, 0, 1, 16'h0000, 16'h1234, 0, 0, 16'h0);
        checkOutput("stb_c1_write", wr1, 1);
        checkOutput("stb_c1_be", be1, 2'b10);
        checkOutput("stb_c1_wdata", wd1, 16'hABAB);
        checkOutput("stb_c1_addr", addr1, 16'h0101);
        applyStimulus(1, 0, 1, 0, 1, 16'h0000, 16'h1234, 1, 1, 16'hDEAD);
        checkOutput("stb_c2_write", wr1, 1);
        checkOutput("stb_c2_adv", adv1, 1);
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        checkOutput("stb_c3_write", wr1, 0);
        checkOutput("stb_c3_busy", busy1, 0);
        checkOutput("stb_c3_rdata", rdata1, 16'h7777);

        // STB to the lower lane and a word STR
        applyStimulus(1, 0, 1, 0, 1, 16'h0100, 16'h00CD, 1, 1, 16'h0);
        checkOutput("stb0_be", be1, 2'b01);
        checkOutput("stb0_wdata", wd1, 16'hCDCD);
        applyStimulus(1, 0, 1, 0, 0, 16'h0102, 16'h1234, 1, 1, 16'h0);
        checkOutput("str_be", be1, 2'b11);
        checkOutput("str_wdata", wd1, 16'h1234);
        checkOutput("str_adv", adv1, 1);

        // LDI with a single pointer level
        doReset();
        applyStimulus(1, 1, 0, 1, 0, 16'h3000, 16'h0, 0, 0, 16'h0);
        checkOutput("ldi1_c0_read", rd1, 1);
        checkOutput("ldi1_c0_addr", addr1, 16'h3000);
        applyStimulus(1, 1, 0, 1, 0, 16'h3000, 16'h0, 0, 1, 16'h4000);
        checkOutput("ldi1_c1_read", rd1, 1);
        checkOutput("ldi1_c1_addr", addr1, 16'h3000);
        checkOutput("ldi1_c1_busy", busy1, 1);
        checkOutput("ldi1_c1_adv", adv1, 0);
        applyStimulus(1, 1, 0, 1, 0, 16'h3000, 16'h0, 1, 1, 16'h5A5A);
        checkOutput("ldi1_c2_read", rd1, 1);
        checkOutput("ldi1_c2_addr", addr1, 16'h4000);
        checkOutput("ldi1_c2_adv", adv1, 1);
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        checkOutput("ldi1_rdata", rdata1, 16'h5A5A);
        checkOutput("ldi1_busy", busy1, 0);

        // LDI through three pointer levels: four reads, then advance
        doReset();
        for (int c = 0; c < 4; c++) begin
            logic [15:0] ret;
            logic [15:0] exp_addr;
            ret      = (c == 3) ? 16'hC0DE : 16'(16'h1000 << c);
            exp_addr = (c == 0) ? 16'h0800 : 16'(16'h0800 << c);
            applyStimulus(1, 1, 0, 1, 0, 16'h0800, 16'h0, (c == 3), 1, ret);
            checkOutput($sformatf("ldi3_read_c%0d", c), rd3, 1);
            checkOutput($sformatf("ldi3_addr_c%0d", c), addr3, exp_addr);
            checkOutput($sformatf("ldi3_adv_c%0d", c), adv3, (c == 3));
        end
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        checkOutput("ldi3_busy", busy3, 0);
        checkOutput("ldi3_rdata", rdata3, 16'hC0DE);

        // STI through two pointer levels: read, read, write
        doReset();
        applyStimulus(1, 0, 1, 1, 0, 16'h0400, 16'h9999, 0, 0, 16'h0);
        checkOutput("sti_c0_read", rd2, 1);
        checkOutput("sti_c0_write", wr2, 0);
        checkOutput("sti_c0_addr", addr2, 16'h0400);
        applyStimulus(1, 0, 1, 1, 0, 16'h0400, 16'h9999, 0, 1, 16'h0500);
        checkOutput("sti_c1_read", rd2, 1);
        checkOutput("sti_c1_write", wr2, 0);
        checkOutput("sti_c1_addr", addr2, 16'h0400);
        applyStimulus(1, 0, 1, 1, 0, 16'h0400, 16'h9999, 0, 1, 16'h0600);
        checkOutput("sti_c2_read", rd2, 1);
        checkOutput("sti_c2_write", wr2, 0);
        checkOutput("sti_c2_addr", addr2, 16'h0500);
        applyStimulus(1, 0, 1, 1, 0, 16'h0400, 16'h9999, 0, 0, 16'h0);
        checkOutput("sti_c3_write", wr2, 1);
        checkOutput("sti_c3_read", rd2, 0);
        checkOutput("sti_c3_addr", addr2, 16'h0600);
        checkOutput("sti_c3_wdata", wd2, 16'h9999);
        checkOutput("sti_c3_be", be2, 2'b11);
        applyStimulus(1, 0, 1, 1, 0, 16'h0400, 16'h9999, 1, 1, 16'hFFFF);
        checkOutput("sti_c4_write", wr2, 1);
        checkOutput("sti_c4_adv", adv2, 1);
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        checkOutput("sti_busy", busy2, 0);
        checkOutput("sti_write_off", wr2, 0);
        checkOutput("sti_rdata", rdata2, 16'h0);

        // Reset while in PTR at level 1, then a plain LDR
        doReset();
        applyStimulus(1, 1, 0, 1, 0, 16'h0700, 16'h0, 0, 1, 16'h0800);
        checkOutput("rptr_c0_read", rd2, 1);
        checkOutput("rptr_c0_addr", addr2, 16'h0700);
        applyStimulus(1, 1, 0, 1, 0, 16'h0700, 16'h0, 0, 0, 16'h0);
        checkOutput("rptr_c1_read", rd2, 1);
        checkOutput("rptr_c1_addr", addr2, 16'h0800);
        checkOutput("rptr_c1_busy", busy2, 1);
        reset = 1'b1;
        #1;
        checkOutput("rptr_rst_read", rd2, 0);
        checkOutput("rptr_rst_write", wr2, 0);
        checkOutput("rptr_rst_busy", busy2, 0);
        checkOutput("rptr_rst_adv", adv2, 0);
        idleInputs();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1, 1, 0, 0, 0, 16'h0010, 16'h0, 0, 0, 16'h0);
        checkOutput("post_c0_read", rd2, 1);
        checkOutput("post_c0_addr", addr2, 16'h0010);
        checkOutput("post_c0_busy", busy2, 0);
        applyStimulus(1, 1, 0, 0, 0, 16'h0010, 16'h0, 1, 1, 16'h2468);
        checkOutput("post_c1_read", rd2, 1);
        checkOutput("post_c1_adv", adv2, 1);
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
        checkOutput("post_busy", busy2, 0);
        checkOutput("post_rdata", rdata2, 16'h2468);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
